// File: rtl/pcie_tx_pkg.sv
// Shared state encoding, grant indices and beat widths for the PCIe transmit arbiter.
package pcie_tx_pkg;

  localparam int DATA_W  = 64;
  localparam int KEEP_W  = DATA_W / 8;

  localparam int GNT_CPL = 0;
  localparam int GNT_WR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPL   = 2'd1,
    ST_WR    = 2'd2,
    ST_FLUSH = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pcie_tx_arbiter.sv
// Packet-level round-robin arbiter putting CPL and WR TLP sources onto the PCIe TX stream.
// Zero-latency datapath while granted, one idle cycle between TLPs, drains the source on link loss.
module pcie_tx_arbiter
  import pcie_tx_pkg::*;
(
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic              user_lnk_up,

  input  logic [DATA_W-1:0] cpl_tdata,
  input  logic [KEEP_W-1:0] cpl_tkeep,
  input  logic              cpl_tlast,
  input  logic              cpl_tvalid,
  output logic              cpl_tready,

  input  logic [DATA_W-1:0] wr_tdata,
  input  logic [KEEP_W-1:0] wr_tkeep,
  input  logic              wr_tlast,
  input  logic              wr_tvalid,
  output logic              wr_tready,

  output logic [DATA_W-1:0] s_axis_tx_tdata,
  output logic [KEEP_W-1:0] s_axis_tx_tkeep,
  output logic              s_axis_tx_tlast,
  output logic              s_axis_tx_tvalid,
  input  logic              s_axis_tx_tready,
  output logic              tx_src_dsc,

  input  logic              cfg_to_turnoff,
  output logic              cfg_turnoff_ok,

  output logic [1:0]        grant
);

  arb_state_t r_state, w_state_nxt;
  logic       r_src, w_src_nxt;   // 1: WR owns the grant, 0: CPL
  logic       r_last_cpl;         // CPL finished the previous TLP, so WR wins the next tie
  logic       r_beat_seen;
  logic       r_dsc;
  logic       r_turnoff_ok;
  logic       w_enter_flush;
  logic       w_busy, w_flush, w_src_vld, w_src_last, w_accept, w_drain, w_done;

  assign w_busy     = (r_state == ST_CPL) || (r_state == ST_WR);
  assign w_flush    = (r_state == ST_FLUSH);
  assign w_src_vld  = r_src ? wr_tvalid : cpl_tvalid;
  assign w_src_last = r_src ? wr_tlast  : cpl_tlast;
  assign w_accept   = w_busy && w_src_vld && s_axis_tx_tready;
  assign w_drain    = w_flush && w_src_vld;
  assign w_done     = (w_accept || w_drain) && w_src_last;

  assign s_axis_tx_tdata  = r_src ? wr_tdata : cpl_tdata;
  assign s_axis_tx_tkeep  = r_src ? wr_tkeep : cpl_tkeep;
  assign s_axis_tx_tlast  = w_src_last;
  assign s_axis_tx_tvalid = w_busy && w_src_vld;

  // While flushing, the owner is drained at full rate and nothing reaches the core.
  assign cpl_tready = !r_src && ((w_busy && s_axis_tx_tready) || w_flush);
  assign wr_tready  =  r_src && ((w_busy && s_axis_tx_tready) || w_flush);

  assign tx_src_dsc     = r_dsc;
  assign cfg_turnoff_ok = r_turnoff_ok;

  always_comb begin
    grant = 2'b00;
    if (w_busy || w_flush) begin
      if (r_src) grant[GNT_WR]  = 1'b1;
      else       grant[GNT_CPL] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_src_nxt     = r_src;
    w_enter_flush = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (user_lnk_up && !cfg_to_turnoff) begin
          if (cpl_tvalid && (!wr_tvalid || !r_last_cpl)) begin
            w_state_nxt = ST_CPL;
            w_src_nxt   = 1'b0;
          end else if (wr_tvalid) begin
            w_state_nxt = ST_WR;
            w_src_nxt   = 1'b1;
          end
        end
      end
      ST_CPL, ST_WR: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end else if (!user_lnk_up) begin
          // An untouched packet is simply retried later; a started one must be discarded.
          if (r_beat_seen || w_accept) begin
            w_state_nxt   = ST_FLUSH;
            w_enter_flush = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_state      <= ST_IDLE;
      r_src        <= 1'b0;
      r_last_cpl   <= 1'b0;
      r_beat_seen  <= 1'b0;
      r_dsc        <= 1'b0;
      r_turnoff_ok <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_src        <= w_src_nxt;
      r_dsc        <= w_enter_flush;
      r_turnoff_ok <= (r_state == ST_IDLE) && cfg_to_turnoff;
      r_beat_seen  <= w_busy && !w_done && (r_beat_seen || w_accept);
      if (w_done) r_last_cpl <= !r_src;
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: AXIS source queues feed the DUT, core-side beats are logged.
module tb_pcie_tx_arbiter;

  logic        user_clk = 1'b0;
  logic        user_reset;
  logic        user_lnk_up;
  logic [63:0] cpl_tdata, wr_tdata, s_axis_tx_tdata;
  logic [7:0]  cpl_tkeep, wr_tkeep, s_axis_tx_tkeep;
  logic        cpl_tlast, cpl_tvalid, cpl_tready;
  logic        wr_tlast, wr_tvalid, wr_tready;
  logic        s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready;
  logic        tx_src_dsc, cfg_to_turnoff, cfg_turnoff_ok;
  logic [1:0]  grant;

  typedef struct {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       cpl_q[$];
  beat_t       wr_q[$];
  logic [63:0] rx_log[$];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 user_clk = ~user_clk;

  pcie_tx_arbiter dut (
    .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
    .cpl_tdata(cpl_tdata), .cpl_tkeep(cpl_tkeep), .cpl_tlast(cpl_tlast),
    .cpl_tvalid(cpl_tvalid), .cpl_tready(cpl_tready),
    .wr_tdata(wr_tdata), .wr_tkeep(wr_tkeep), .wr_tlast(wr_tlast),
    .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
    .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
    .s_axis_tx_tready(s_axis_tx_tready), .tx_src_dsc(tx_src_dsc),
    .cfg_to_turnoff(cfg_to_turnoff), .cfg_turnoff_ok(cfg_turnoff_ok),
    .grant(grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bv(input int src, input int pkt, input int b);
    return {(src != 0) ? 32'hAAAA_5A5A : 32'hCCCC_3C3C, pkt[15:0], b[15:0]};
  endfunction

  task automatic load(input int src, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      bt.dat  = bv(src, pkt, b);
      bt.keep = (b == nb - 1) ? 8'h0F : 8'hFF;
      bt.last = (b == nb - 1);
      if (src != 0) wr_q.push_back(bt);
      else          cpl_q.push_back(bt);
    end
  endtask

  task automatic drive();
    cpl_tvalid = 1'b0; cpl_tdata = '0; cpl_tkeep = '0; cpl_tlast = 1'b0;
    wr_tvalid  = 1'b0; wr_tdata  = '0; wr_tkeep  = '0; wr_tlast  = 1'b0;
    if (cpl_q.size() > 0) begin
      cpl_tvalid = 1'b1; cpl_tdata = cpl_q[0].dat; cpl_tkeep = cpl_q[0].keep; cpl_tlast = cpl_q[0].last;
    end
    if (wr_q.size() > 0) begin
      wr_tvalid = 1'b1; wr_tdata = wr_q[0].dat; wr_tkeep = wr_q[0].keep; wr_tlast = wr_q[0].last;
    end
  endtask

  // One clock: record handshakes just before the edge, advance sources after it.
  task automatic step();
    logic hc, hw;
    #1;
    hc = cpl_tvalid && cpl_tready;
    hw = wr_tvalid && wr_tready;
    if (s_axis_tx_tvalid && s_axis_tx_tready) rx_log.push_back(s_axis_tx_tdata);
    @(posedge user_clk);
    #1;
    if (hc) cpl_q.delete(0);
    if (hw) wr_q.delete(0);
    drive();
    #1;
  endtask

  task automatic run_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((cpl_q.size() > 0 || wr_q.size() > 0 || grant != 2'b00) && n < bound) begin
      step();
      n++;
    end
    check(tag, (cpl_q.size() == 0 && wr_q.size() == 0 && grant == 2'b00), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_dsc, n_vld;
    user_reset = 1'b1; user_lnk_up = 1'b1; cfg_to_turnoff = 1'b0; s_axis_tx_tready = 1'b1;
    drive();
    step(); step();
    check("rst_vld", s_axis_tx_tvalid, 0);
    check("rst_cpl_rdy", cpl_tready, 0);
    check("rst_wr_rdy", wr_tready, 0);
    check("rst_dsc", tx_src_dsc, 0);
    check("rst_ok", cfg_turnoff_ok, 0);
    check("rst_gnt", grant, 2'b00);
    user_reset = 1'b0;
    step();

    // CPL only, 3 beats
    load(0, 0, 3); drive(); #1;
    check("t1_pre_vld", s_axis_tx_tvalid, 0);
    for (int b = 0; b < 3; b++) begin
      step();
      check("t1_vld", s_axis_tx_tvalid, 1);
      check("t1_dat", s_axis_tx_tdata, bv(0, 0, b));
      check("t1_gnt", grant, 2'b01);
      check("t1_wr_rdy", wr_tready, 0);
    end
    check("t1_keep", s_axis_tx_tkeep, 8'h0F);
    check("t1_last", s_axis_tx_tlast, 1);
    step();
    check("t1_end_gnt", grant, 2'b00);
    check("t1_end_vld", s_axis_tx_tvalid, 0);

    // Both pending from reset: CPL,WR alternate with one bubble between TLPs
    user_reset = 1'b1; step(); user_reset = 1'b0;
    load(0, 0, 2); load(0, 1, 2); load(0, 2, 2);
    load(1, 0, 2); load(1, 1, 2); load(1, 2, 2);
    drive();
    for (int k = 1; k <= 18; k++) begin
      int ph, j;
      step();
      ph = (k - 1) % 3;
      j  = (k - 1) / 3;
      if (ph == 2) begin
        check("t2_bubble", grant, 2'b00);
      end else begin
        check("t2_gnt", grant, (j % 2 != 0) ? 2'b10 : 2'b01);
        check("t2_dat", s_axis_tx_tdata, bv(j % 2, j / 2, ph));
      end
    end

    // WR 4 beats against a toggling core tready, CPL arrives mid-packet
    rx_log.delete(); s_axis_tx_tready = 1'b1;
    load(1, 5, 4); drive();
    step();
    load(0, 6, 2); drive();
    n = 0;
    while (wr_q.size() > 0 && n < 30) begin
      s_axis_tx_tready = !s_axis_tx_tready;
      #1;
      check("t3_rdy_ret", wr_tready, s_axis_tx_tready);
      check("t3_no_cpl", cpl_tready, 0);
      step();
      n++;
    end
    s_axis_tx_tready = 1'b1;
    run_idle("t3_done", 20);
    check("t3_cnt", rx_log.size(), 6);
    for (int b = 0; b < 4; b++) check("t3_wr_beat", rx_log[b], bv(1, 5, b));
    check("t3_cpl_after", rx_log[4], bv(0, 6, 0));

    // Link drops after 2 of 5 WR beats: discontinue and drain the rest
    rx_log.delete();
    load(1, 4, 5); drive();
    step(); step(); step();
    user_lnk_up = 1'b0; s_axis_tx_tready = 1'b0;
    step();
    check("t4_dsc", tx_src_dsc, 1);
    check("t4_vld", s_axis_tx_tvalid, 0);
    check("t4_drain_rdy", wr_tready, 1);
    check("t4_gnt", grant, 2'b10);
    s_axis_tx_tready = 1'b1;
    n = 0; n_dsc = 0; n_vld = 0;
    while (grant != 2'b00 && n < 12) begin
      step();
      n++;
      n_dsc += int'(tx_src_dsc);
      n_vld += int'(s_axis_tx_tvalid);
    end
    check("t4_drained", wr_q.size(), 0);
    check("t4_idle", grant, 2'b00);
    check("t4_dsc_once", n_dsc, 0);
    check("t4_no_vld", n_vld, 0);
    check("t4_core_cnt", rx_log.size(), 2);
    check("t4_core_b1", rx_log[1], bv(1, 4, 1));

    // Link drops before any beat: packet left in place and retried
    user_lnk_up = 1'b1; s_axis_tx_tready = 1'b0; rx_log.delete();
    load(1, 8, 2); drive();
    step();
    check("t4b_gnt", grant, 2'b10);
    user_lnk_up = 1'b0;
    step();
    check("t4b_idle", grant, 2'b00);
    check("t4b_no_dsc", tx_src_dsc, 0);
    check("t4b_kept", wr_q.size(), 2);
    step();
    check("t4b_down_rdy", wr_tready, 0);
    check("t4b_down_gnt", grant, 2'b00);
    user_lnk_up = 1'b1; s_axis_tx_tready = 1'b1;
    run_idle("t4b_done", 20);
    check("t4b_cnt", rx_log.size(), 2);
    check("t4b_b0", rx_log[0], bv(1, 8, 0));

    // Turnoff requested mid CPL packet with WR pending
    load(0, 2, 3); drive();
    step(); step();
    cfg_to_turnoff = 1'b1;
    load(1, 3, 2); drive();
    step();
    check("t5_busy_ok", cfg_turnoff_ok, 0);
    check("t5_dat", s_axis_tx_tdata, bv(0, 2, 2));
    step();
    check("t5_idle_gnt", grant, 2'b00);
    check("t5_idle_ok", cfg_turnoff_ok, 0);
    step();
    check("t5_ok", cfg_turnoff_ok, 1);
    check("t5_blocked", grant, 2'b00);
    check("t5_wr_rdy", wr_tready, 0);
    cfg_to_turnoff = 1'b0;
    #1;
    check("t5_ok_hold", cfg_turnoff_ok, 1);
    step();
    check("t5_ok_fall", cfg_turnoff_ok, 0);
    check("t5_wr_gnt", grant, 2'b10);
    run_idle("t5_done", 20);

    // Reset during beat 2 of a CPL packet
    load(0, 9, 3); drive();
    step(); step();
    check("t6_gnt", grant, 2'b01);
    user_reset = 1'b1;
    step();
    check("t6_gnt_rst", grant, 2'b00);
    check("t6_vld_rst", s_axis_tx_tvalid, 0);
    check("t6_cpl_rdy", cpl_tready, 0);
    check("t6_wr_rdy", wr_tready, 0);
    check("t6_dsc", tx_src_dsc, 0);
    check("t6_ok", cfg_turnoff_ok, 0);
    user_reset = 1'b0;
    cpl_q.delete(); wr_q.delete(); drive();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-level arbiter sharing the single PCIe AXI4-Stream transmit port (`s_axis_tx_*`) between two 64-bit TLP sources inside PIO: the completion engine (CPL, answers host MMIO reads) and the write requester (WR, memory-write TLPs generated from XGMII receive traffic). Grants are held for a whole TLP and alternate round-robin when both sources are pending. The block also owns the transmit side of the power-down handshake (`cfg_to_turnoff`/`cfg_turnoff_ok`) and flushes a source cleanly when the link drops.

## Interface
- `DATA_W`, 64: TLP beat width; `KEEP_W` = DATA_W/8.
- `user_clk` in 1: sole clock, 250 MHz PCIe user clock.
- `user_reset` in 1: synchronous, active-high reset.
- `user_lnk_up` in 1: PCIe link up.
- `cpl_tdata/tkeep/tlast/tvalid` in 64/8/1/1: completion source stream; `cpl_tready` out 1.
- `wr_tdata/tkeep/tlast/tvalid` in 64/8/1/1: write-request source stream; `wr_tready` out 1.
- `s_axis_tx_tdata/tkeep/tlast/tvalid` out 64/8/1/1: to PCIe core; `s_axis_tx_tready` in 1.
- `tx_src_dsc` out 1: source discontinue to core.
- `cfg_to_turnoff` in 1: core requests turnoff; `cfg_turnoff_ok` out 1: arbiter quiescent, turnoff permitted.
- `grant` out 2: {WR, CPL} one-hot grant for debug/LED; 00 when idle.

## Operation
- FSM states: IDLE, CPL, WR, FLUSH.
- IDLE: if `user_lnk_up`=1 and `cfg_to_turnoff`=0: pending = {wr_tvalid, cpl_tvalid}. Single pending -> grant it. Both pending -> grant the source not served last (`last_wr` flag; reset value 0, so CPL wins first tie). Nothing pending -> stay.
- CPL/WR: output stream = granted source's stream, combinational mux; granted tready = `s_axis_tx_tready`; non-granted tready = 0. On beat accepted with tlast (tvalid & tready & tlast) -> IDLE, update `last_wr`.
- Link loss: `user_lnk_up`=0 while in CPL/WR and after ≥1 beat accepted -> FLUSH; if no beat accepted yet -> IDLE (packet untouched, retried later). `tx_src_dsc` pulses 1 cycle on FLUSH entry.
- FLUSH: `s_axis_tx_tvalid`=0; granted source tready=1 (drain); on drained tlast -> IDLE. No beat reaches the core.
- Turnoff: `cfg_to_turnoff`=1 blocks new grants; a packet in progress completes normally. `cfg_turnoff_ok`=1 (registered) while state=IDLE and `cfg_to_turnoff`=1; deasserts the cycle after `cfg_to_turnoff` falls.
- `user_lnk_up`=0 in IDLE: no grants, both treadys 0.

## Timing
- Reset values: state IDLE, `s_axis_tx_tvalid` 0, `cpl_tready`/`wr_tready` 0, `tx_src_dsc` 0, `cfg_turnoff_ok` 0, `grant` 00, `last_wr` 0.
- Grant latency: source tvalid seen in IDLE at cycle N -> first beat presented to core at N+1.
- Zero-latency datapath while granted; the core's tready is returned combinationally.
- One idle bubble between consecutive TLPs (tlast accepted at N, IDLE at N+1, next grant beat at N+2).
- Single-beat TLP (tlast on first beat) valid; grant lasts exactly one accepted cycle.
- Sources must obey AXIS: tvalid held until accepted, data stable; arbiter does not re-check.
- Reset mid-packet: immediate IDLE, all outputs to reset values next edge; no dsc pulse.

## Structure
- Shared package `pcie_tx_pkg`: state encoding (IDLE/CPL/WR/FLUSH), grant index constants (GNT_CPL=0, GNT_WR=1), DATA_W/KEEP_W.
- No sub-module; FSM + 2:1 stream mux fit in one file (~150 lines).

## Test plan
- CPL only, 3-beat TLP, tready=1 -> beats on `s_axis_tx_*` at cycles 1-3 after tvalid, `grant`=01, IDLE after tlast, `wr_tready`=0 throughout.
- Both pending from reset, 2-beat TLPs each, repeated 3 times -> order CPL,WR,CPL,WR,CPL,WR; one bubble between packets.
- Core tready toggles 1/0 every cycle during 4-beat WR TLP -> all 4 beats delivered in order, unchanged, no interleaved CPL beats.
- `user_lnk_up` drops after beat 2 of 5-beat WR TLP -> `tx_src_dsc` one-cycle pulse, `s_axis_tx_tvalid`=0, beats 3-5 drained via `wr_tready`=1, back to IDLE.
- `cfg_to_turnoff`=1 mid CPL packet with WR pending -> CPL completes, WR not granted, `cfg_turnoff_ok`=1 the cycle after IDLE reached; falls after `cfg_to_turnoff` drops, then WR granted.
- `user_reset` asserted during beat 2 -> next cycle all outputs at reset values, `grant`=00.
